// File: rtl/data_path.sv
// data_path: 32-bit single-bus CPU datapath. A general register file, the
// special registers (PC, IR, Y, Z, HI, LO, MAR, MDR, ports, CON), the ALU and
// the IR select-and-encode logic all share one bus. An external controller
// sequences everything through one-bit strobes.
module data_path #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             PCout,
  input  logic             Zhighout,
  input  logic             Zlowout,
  input  logic             MDRout,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             Yout,
  input  logic             InPortout,
  input  logic             Cout,
  input  logic             Rout,
  input  logic             BAout,
  input  logic             MARin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             ZHighIn,
  input  logic             ZLowIn,
  input  logic             Rin,
  input  logic             CONin,
  input  logic             OutPortin,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             Write,
  input  logic [4:0]       opcode,
  input  logic [8:0]       Address,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [WIDTH-1:0] InPortData,
  output logic             R0out,
  output logic             R1out,
  output logic             R2out,
  output logic             R3out,
  output logic             R4out,
  output logic             R5out,
  output logic             R6out,
  output logic             R7out,
  output logic             R8out,
  output logic             R9out,
  output logic             R10out,
  output logic             R11out,
  output logic             R12out,
  output logic             R13out,
  output logic             R14out,
  output logic             R15out,
  output logic             CON_out,
  output logic [WIDTH-1:0] OutPortData
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_zHigh;
  logic [WIDTH-1:0] r_zLow;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [8:0]       r_mar;
  logic [WIDTH-1:0] r_mdr;
  logic [WIDTH-1:0] r_inPort;
  logic [WIDTH-1:0] r_outPort;
  logic             r_con;

  logic [3:0]           w_sel;
  logic [NREGS-1:0]     w_rOut;
  logic [WIDTH-1:0]     w_cSext;
  logic [WIDTH-1:0]     w_bus;
  logic [WIDTH-1:0]     w_mdrIn;
  logic [2*WIDTH-1:0]   w_alu;
  logic [2*WIDTH-1:0]   w_rotR;
  logic [2*WIDTH-1:0]   w_rotL;
  logic signed [WIDTH-1:0]   w_sy;
  logic signed [WIDTH-1:0]   w_sb;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [WIDTH-1:0]   w_quot;
  logic signed [WIDTH-1:0]   w_rem;
  logic [4:0]           w_shamt;
  logic                 w_conCond;
  logic                 w_unused;

  // The address port, the write strobe, MAR and the IR opcode bits have no
  // consumer inside this block; they are folded here on purpose.
  assign w_unused = ^{Address, Write, r_mar, r_ir[31:27]};

  assign w_sel = ({4{Gra}} & r_ir[26:23]) |
                 ({4{Grb}} & r_ir[22:19]) |
                 ({4{Grc}} & r_ir[18:15]);

  assign w_cSext = {{(WIDTH-19){r_ir[18]}}, r_ir[18:0]};
  assign w_mdrIn = Read ? Mdatain : w_bus;

  // Decode the selected register index into per-register drive enables.
  always_comb begin
    w_rOut = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_rOut[i] = (Rout | BAout) & (w_sel == 4'(i));
    end
  end

  assign R0out  = w_rOut[0];
  assign R1out  = w_rOut[1];
  assign R2out  = w_rOut[2];
  assign R3out  = w_rOut[3];
  assign R4out  = w_rOut[4];
  assign R5out  = w_rOut[5];
  assign R6out  = w_rOut[6];
  assign R7out  = w_rOut[7];
  assign R8out  = w_rOut[8];
  assign R9out  = w_rOut[9];
  assign R10out = w_rOut[10];
  assign R11out = w_rOut[11];
  assign R12out = w_rOut[12];
  assign R13out = w_rOut[13];
  assign R14out = w_rOut[14];
  assign R15out = w_rOut[15];

  // Bus mux: lowest-priority driver is assigned first so later ones win; R0 under BAout reads as zero.
  always_comb begin
    w_bus = '0;
    if (Cout)      w_bus = w_cSext;
    if (Yout)      w_bus = r_y;
    if (InPortout) w_bus = r_inPort;
    if (MDRout)    w_bus = r_mdr;
    if (PCout)     w_bus = r_pc;
    if (Zlowout)   w_bus = r_zLow;
    if (Zhighout)  w_bus = r_zHigh;
    if (LOout)     w_bus = r_lo;
    if (HIout)     w_bus = r_hi;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (w_rOut[i]) w_bus = ((i == 0) && BAout) ? '0 : r_regs[i];
    end
  end

  assign w_sy    = r_y;
  assign w_sb    = w_bus;
  assign w_shamt = w_bus[4:0];
  assign w_rotR  = {r_y, r_y} >> w_shamt;
  assign w_rotL  = {r_y, r_y} << w_shamt;
  assign w_prod  = $signed({{WIDTH{w_sy[WIDTH-1]}}, w_sy}) *
                   $signed({{WIDTH{w_sb[WIDTH-1]}}, w_sb});
  assign w_quot  = w_sy / w_sb;
  assign w_rem   = w_sy % w_sb;

  // ALU: A is Y, B is the bus; IncPC forces B+1 regardless of opcode.
  always_comb begin
    w_alu = '0;
    if (IncPC) begin
      w_alu[WIDTH-1:0] = w_bus + 1'b1;
    end else begin
      case (opcode)
        5'b00100:          w_alu[WIDTH-1:0] = r_y - w_bus;
        5'b00101, 5'b01101: w_alu[WIDTH-1:0] = r_y & w_bus;
        5'b00110, 5'b01110: w_alu[WIDTH-1:0] = r_y | w_bus;
        5'b00111:          w_alu[WIDTH-1:0] = w_rotR[WIDTH-1:0];
        5'b01000:          w_alu[WIDTH-1:0] = w_rotL[2*WIDTH-1:WIDTH];
        5'b01001:          w_alu[WIDTH-1:0] = r_y >> w_shamt;
        5'b01010:          w_alu[WIDTH-1:0] = w_sy >>> w_shamt;
        5'b01011:          w_alu[WIDTH-1:0] = r_y << w_shamt;
        5'b01111: begin
          if (w_bus != '0) w_alu = {w_rem, w_quot};
        end
        5'b10000:          w_alu = w_prod;
        5'b10001:          w_alu[WIDTH-1:0] = -w_bus;
        5'b10010:          w_alu[WIDTH-1:0] = ~w_bus;
        default:           w_alu[WIDTH-1:0] = r_y + w_bus;
      endcase
    end
  end

  // Branch condition chosen by IR[20:19], evaluated on the current bus value.
  always_comb begin
    case (r_ir[20:19])
      2'b00:   w_conCond = (w_bus == '0);
      2'b01:   w_conCond = (w_bus != '0);
      2'b10:   w_conCond = ~w_bus[WIDTH-1];
      default: w_conCond = w_bus[WIDTH-1];
    endcase
  end

  // General register file: Rin writes the register picked by the IR field select.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (Rin) begin
      r_regs[w_sel] <= w_bus;
    end
  end

  // Special-purpose registers, each loading from the bus on its own strobe.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_y   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
    end else begin
      if (PCin)  r_pc  <= w_bus;
      if (IRin)  r_ir  <= w_bus;
      if (Yin)   r_y   <= w_bus;
      if (HIin)  r_hi  <= w_bus;
      if (LOin)  r_lo  <= w_bus;
      if (MARin) r_mar <= w_bus[8:0];
      if (MDRin) r_mdr <= w_mdrIn;
    end
  end

  // Z holds the 64-bit ALU result, with independent high and low load strobes.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_zHigh <= '0;
      r_zLow  <= '0;
    end else begin
      if (ZHighIn) r_zHigh <= w_alu[2*WIDTH-1:WIDTH];
      if (ZLowIn)  r_zLow  <= w_alu[WIDTH-1:0];
    end
  end

  // I/O ports and CON: InPort samples every edge, OutPort and CON load on strobe.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_inPort  <= '0;
      r_outPort <= '0;
      r_con     <= 1'b0;
    end else begin
      r_inPort <= InPortData;
      if (OutPortin) r_outPort <= w_bus;
      if (CONin)     r_con     <= w_conCond;
    end
  end

  assign CON_out     = r_con;
  assign OutPortData = r_outPort;

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: drives data_path through micro-operation sequences and reads
// internal state back through the bus into OutPort, comparing every result
// against a behavioural model of the register contents and ALU.
module tb_data_path;

  logic clock, clear;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout, Rout, BAout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin, OutPortin;
  logic Gra, Grb, Grc, IncPC, Read, Write;
  logic [4:0]  opcode;
  logic [8:0]  Address;
  logic [31:0] Mdatain, InPortData;
  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
  logic CON_out;
  logic [31:0] OutPortData;
  logic [15:0] rOutVec;

  int checkCount = 0;
  int passCount  = 0;

  // Behavioural model state
  logic [31:0] mRegs [16];
  logic [31:0] mPc, mY, mHi, mLo, mMdr, mInPort;
  logic [63:0] mZ;
  logic        mCon;

  assign rOutVec = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  data_path #(.WIDTH(32), .NREGS(16)) dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Yout(Yout), .InPortout(InPortout),
    .Cout(Cout), .Rout(Rout), .BAout(BAout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Rin(Rin),
    .CONin(CONin), .OutPortin(OutPortin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
    .opcode(opcode), .Address(Address), .Mdatain(Mdatain), .InPortData(InPortData),
    .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
    .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
    .R8out(R8out), .R9out(R9out), .R10out(R10out), .R11out(R11out),
    .R12out(R12out), .R13out(R13out), .R14out(R14out), .R15out(R15out),
    .CON_out(CON_out), .OutPortData(OutPortData)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Counts one comparison and reports it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    else
      passCount++;
  endtask

  task automatic idle();
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout, Rout, BAout} = '0;
    {MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin, OutPortin} = '0;
    {Gra, Grb, Grc, IncPC, Read, Write} = '0;
    opcode = '0;
  endtask

  task automatic resetModel();
    foreach (mRegs[i]) mRegs[i] = '0;
    {mPc, mY, mHi, mLo, mMdr, mInPort} = '0;
    mZ = '0;
    mCon = 1'b0;
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
    mInPort = InPortData;
    idle();
  endtask

  // Caller has already raised one drive strobe; latch the bus in OutPort and compare
  task automatic checkPort(input string tag, input logic [31:0] exp);
    OutPortin = 1'b1;
    stepClock();
    checkOutput(tag, OutPortData, exp);
  endtask

  task automatic memToMdr(input logic [31:0] v);
    Read = 1'b1; MDRin = 1'b1; Mdatain = v;
    stepClock();
    mMdr = v;
  endtask

  task automatic setIr(input logic [31:0] v);
    memToMdr(v);
    MDRout = 1'b1; IRin = 1'b1;
    stepClock();
  endtask

  task automatic writeReg(input int k, input logic [31:0] v);
    setIr(32'(k) << 23);
    memToMdr(v);
    Gra = 1'b1; MDRout = 1'b1; Rin = 1'b1;
    stepClock();
    mRegs[k] = v;
  endtask

  task automatic readReg(input int k);
    setIr(32'(k) << 19);
    Grb = 1'b1; Rout = 1'b1;
    checkPort($sformatf("R%0d", k), mRegs[k]);
  endtask

  task automatic loadY(input logic [31:0] v);
    memToMdr(v);
    MDRout = 1'b1; Yin = 1'b1;
    stepClock();
    mY = v;
  endtask

  // Reference ALU, computed bit-by-bit or with plain signed arithmetic
  function automatic logic [63:0] aluRef(input int op, input logic [31:0] a,
                                         input logic [31:0] b, input bit inc);
    logic [31:0] r;
    int n;
    int q, rm;
    n = int'(b[4:0]);
    r = a;
    if (inc) return {32'h0, b + 32'd1};
    case (op)
      4:       return {32'h0, a - b};
      5, 13:   return {32'h0, a & b};
      6, 14:   return {32'h0, a | b};
      7:  begin repeat (n) r = {r[0], r[31:1]};    return {32'h0, r}; end
      8:  begin repeat (n) r = {r[30:0], r[31]};   return {32'h0, r}; end
      9:  begin repeat (n) r = {1'b0, r[31:1]};    return {32'h0, r}; end
      10: begin repeat (n) r = {r[31], r[31:1]};   return {32'h0, r}; end
      11: begin repeat (n) r = {r[30:0], 1'b0};    return {32'h0, r}; end
      15: begin
        if (b == 0) return 64'h0;
        q  = int'(a) / int'(b);
        rm = int'(a) % int'(b);
        return {32'(rm), 32'(q)};
      end
      16:      return 64'(longint'(int'(a)) * longint'(int'(b)));
      17:      return {32'h0, 32'h0 - b};
      18:      return {32'h0, ~b};
      default: return {32'h0, a + b};
    endcase
  endfunction

  function automatic bit conRef(input logic [1:0] c, input logic [31:0] v);
    case (c)
      2'd0:    return v == 0;
      2'd1:    return v != 0;
      2'd2:    return !v[31];
      default: return v[31];
    endcase
  endfunction

  // Y=a, bus=b from MDR, load both Z halves, then read them back
  task automatic applyStimulus(input int op, input logic [31:0] a, input logic [31:0] b,
                               input bit inc, input logic [63:0] expZ, input string tag);
    loadY(a);
    memToMdr(b);
    MDRout = 1'b1; opcode = 5'(op); IncPC = inc; ZHighIn = 1'b1; ZLowIn = 1'b1;
    stepClock();
    mZ = expZ;
    Zlowout = 1'b1;
    checkPort($sformatf("%s op%0d zlo a=%08h b=%08h", tag, op, a, b), mZ[31:0]);
    Zhighout = 1'b1;
    checkPort($sformatf("%s op%0d zhi a=%08h b=%08h", tag, op, a, b), mZ[63:32]);
  endtask

  initial begin
    logic [31:0] a, b, v;
    logic [1:0]  c;
    int op, k;
    bit inc;

    idle();
    clear = 1'b1; Address = '0; Mdatain = '0; InPortData = '0;
    resetModel();
    #3 clear = 1'b0;
    #2;
    checkOutput("reset outport", OutPortData, 32'h0);
    checkOutput("reset con", {31'h0, CON_out}, 32'h0);
    checkOutput("reset rout", {16'h0, rOutVec}, 32'h0);
    #7 clear = 1'b1;
    @(posedge clock); #1;
    mInPort = InPortData;
    PCout = 1'b1;  checkPort("reset pc", 32'h0);
    readReg(7);

    // Register file: write every register, read each back via Rb/Rout
    for (int i = 0; i < 16; i++) writeReg(i, $urandom);
    for (int i = 0; i < 16; i++) readReg(i);

    // Select-and-encode decoding on each field
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, 15);
      setIr((32'(k) << 23) | (32'((k + 5) % 16) << 19) | (32'((k + 9) % 16) << 15));
      Gra = 1'b1; Rout = 1'b1; #1;
      checkOutput("decode gra", {16'h0, rOutVec}, 32'h1 << k);
      Gra = 1'b0; Grb = 1'b1; #1;
      checkOutput("decode grb", {16'h0, rOutVec}, 32'h1 << ((k + 5) % 16));
      Grb = 1'b0; Grc = 1'b1; Rout = 1'b0; BAout = 1'b1; #1;
      checkOutput("decode grc ba", {16'h0, rOutVec}, 32'h1 << ((k + 9) % 16));
      idle();
    end

    // Fetch sequence
    memToMdr(32'd5); MDRout = 1'b1; PCin = 1'b1; stepClock(); mPc = 32'd5;
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; stepClock();
    mZ[31:0] = mPc + 1;
    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h00880064;
    stepClock();
    mPc = mZ[31:0]; mMdr = 32'h00880064;
    MDRout = 1'b1; IRin = 1'b1; stepClock();
    Gra = 1'b1; Rout = 1'b1; #1;
    checkOutput("fetch ir ra", {16'h0, rOutVec}, 32'h0002);
    idle();
    Cout = 1'b1;  checkPort("fetch ir c", 32'h64);
    PCout = 1'b1; checkPort("fetch pc", 32'h6);

    // ld with Rb=1 and Rb=0
    for (int pass = 0; pass < 2; pass++) begin
      writeReg(0, 32'h55);
      writeReg(1, 32'h10);
      setIr(pass == 0 ? 32'h00880064 : 32'h00800064);
      Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; stepClock();
      mY = (pass == 0) ? mRegs[1] : 32'h0;
      Cout = 1'b1; opcode = 5'b00011; ZLowIn = 1'b1; stepClock();
      mZ[31:0] = mY + 32'h64;
      Zlowout = 1'b1; checkPort("ld ea", pass == 0 ? 32'h74 : 32'h64);
      memToMdr(32'hAB);
      Gra = 1'b1; MDRout = 1'b1; Rin = 1'b1; stepClock();
      mRegs[1] = 32'hAB;
      readReg(1);
      readReg(0);
    end

    // C sign extension
    setIr(32'h00040000);
    Cout = 1'b1; checkPort("c sext", 32'hFFFC0000);

    // Fixed ALU cases
    applyStimulus(16, 32'hFFFFFFFE, 32'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFA, "mul");
    applyStimulus(15, 32'd17, 32'd5, 1'b0, {32'd2, 32'd3}, "div");
    applyStimulus(15, 32'd17, 32'd0, 1'b0, 64'h0, "div0");
    applyStimulus(3, 32'hFFFFFFFF, 32'd1, 1'b0, 64'h0, "addwrap");
    applyStimulus(4, 32'h0, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, "subwrap");

    // Randomized ALU operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 31);
      a = $urandom; b = $urandom;
      inc = ($urandom_range(0, 7) == 0);
      if (op == 15 && $urandom_range(0, 3) == 0) b = 0;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      applyStimulus(op, a, b, inc, aluRef(op, a, b, inc), "rnd");
    end

    // HI, LO, Y, InPort and bus priority
    v = $urandom; memToMdr(v); MDRout = 1'b1; HIin = 1'b1; stepClock(); mHi = v;
    v = $urandom; memToMdr(v); MDRout = 1'b1; LOin = 1'b1; stepClock(); mLo = v;
    HIout = 1'b1; checkPort("hi", mHi);
    LOout = 1'b1; checkPort("lo", mLo);
    loadY($urandom);
    Yout = 1'b1; checkPort("y", mY);
    InPortData = $urandom; stepClock();
    InPortout = 1'b1; checkPort("inport", mInPort);
    memToMdr($urandom);
    MDRout = 1'b1; Yout = 1'b1; checkPort("prio mdr over y", mMdr);
    HIout = 1'b1; LOout = 1'b1; checkPort("prio hi over lo", mHi);

    // CON conditions
    setIr(32'h1 << 19);
    memToMdr(32'h0); MDRout = 1'b1; CONin = 1'b1; stepClock();
    checkOutput("con ne bus0", {31'h0, CON_out}, 32'h0);
    memToMdr(32'h7); MDRout = 1'b1; CONin = 1'b1; stepClock();
    checkOutput("con ne bus7", {31'h0, CON_out}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      c = 2'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      setIr(32'(c) << 19);
      memToMdr(v); MDRout = 1'b1; CONin = 1'b1; stepClock();
      mCon = conRef(c, v);
      checkOutput($sformatf("con c=%0d v=%08h", c, v), {31'h0, CON_out}, {31'h0, mCon});
    end

    // OutPort load
    memToMdr(32'h1234); MDRout = 1'b1; checkPort("outport", 32'h1234);

    // Mid-run asynchronous clear
    setIr(32'h0);
    memToMdr(32'h0); MDRout = 1'b1; CONin = 1'b1; stepClock();
    checkOutput("con pre-clear", {31'h0, CON_out}, 32'h1);
    #2 clear = 1'b0;
    #1;
    checkOutput("clear outport", OutPortData, 32'h0);
    checkOutput("clear con", {31'h0, CON_out}, 32'h0);
    #1 clear = 1'b1;
    resetModel();
    InPortData = '0;
    @(posedge clock); #1;
    PCout = 1'b1;   checkPort("clear pc", 32'h0);
    HIout = 1'b1;   checkPort("clear hi", 32'h0);
    Zlowout = 1'b1; checkPort("clear zlo", 32'h0);
    Yout = 1'b1;    checkPort("clear y", 32'h0);
    readReg(1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
